aes_decrypt_key_expand: RTL and testbench

//  Round-key generator for the AES-128 decryption datapath. It mirrors the encrypt key expander,

---
 rtl/aes_decrypt_key_expand.sv | 169 ++++++++++++++++
 tb/tb_aes_decrypt_key_expand.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/aes_decrypt_key_expand.sv
// AES-128 decryption round-key generator: runs the forward schedule to K10 on a key load,
// then emits K10 down to K0 one key per key_next using the inverse key schedule.
module aes_decrypt_key_expand #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [127:0] cipher_key,
  input  logic         key_load,
  input  logic         key_next,
  input  logic         key_rewind,
  output logic [127:0] round_key_out,
  output logic [3:0]   round_idx,
  output logic         key_valid,
  output logic         busy,
  output logic         last_key
);

  typedef enum logic [1:0] {IDLE, EXPAND, READY} state_e;

  localparam logic [3:0] LAST_RND = 4'(NR);

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] sbox(input logic [7:0] b);
    // Entry 0 sits in the top byte of the table, so byte b lives at offset (255-b)*8.
    return SBOX_TBL[{~b, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] w);
    return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
  endfunction

  function automatic logic [31:0] rot_word(input logic [31:0] w);
    return {w[23:0], w[31:24]};
  endfunction

  function automatic logic [31:0] rcon(input logic [3:0] i);
    logic [7:0] rc;
    case (i)
      4'd1:    rc = 8'h01;
      4'd2:    rc = 8'h02;
      4'd3:    rc = 8'h04;
      4'd4:    rc = 8'h08;
      4'd5:    rc = 8'h10;
      4'd6:    rc = 8'h20;
      4'd7:    rc = 8'h40;
      4'd8:    rc = 8'h80;
      4'd9:    rc = 8'h1b;
      4'd10:   rc = 8'h36;
      default: rc = 8'h00;
    endcase
    return {rc, 24'h0};
  endfunction

  state_e       state_q;
  logic [127:0] key_q;
  logic [127:0] k10_q;
  logic [3:0]   cnt_q;
  logic [3:0]   idx_q;
  logic         valid_q;
  logic         busy_q;
  logic         last_q;

  logic         expanding;
  logic [3:0]   cnt_nxt;
  logic [3:0]   rc_idx;
  logic [31:0]  w0, w1, w2, w3;
  logic [31:0]  w1p, w2p, w3p;
  logic [31:0]  sub_in, t;
  logic [31:0]  f0, f1, f2, f3;
  logic [127:0] key_fwd, key_inv;

  assign expanding = (state_q == EXPAND);
  assign cnt_nxt   = cnt_q + 4'd1;

  assign w0 = key_q[127:96];
  assign w1 = key_q[95:64];
  assign w2 = key_q[63:32];
  assign w3 = key_q[31:0];

  assign w3p = w3 ^ w2;
  assign w2p = w2 ^ w1;
  assign w1p = w1 ^ w0;

  // One S-box word serves both directions: forward needs w3, inverse needs the recovered w3p.
  assign sub_in = expanding ? w3 : w3p;
  assign rc_idx = expanding ? cnt_nxt : idx_q;
  assign t      = sub_word(rot_word(sub_in)) ^ rcon(rc_idx);

  assign f0 = w0 ^ t;
  assign f1 = w1 ^ f0;
  assign f2 = w2 ^ f1;
  assign f3 = w3 ^ f2;

  assign key_fwd = {f0, f1, f2, f3};
  assign key_inv = {w0 ^ t, w1p, w2p, w3p};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      key_q   <= '0;
      k10_q   <= '0;
      cnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
      last_q  <= 1'b0;
    end else if (key_load) begin
      state_q <= EXPAND;
      key_q   <= cipher_key;
      cnt_q   <= '0;
      idx_q   <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b1;
      last_q  <= 1'b0;
    end else begin
      case (state_q)
        EXPAND: begin
          key_q <= key_fwd;
          cnt_q <= cnt_nxt;
          if (cnt_nxt == LAST_RND) begin
            k10_q   <= key_fwd;
            state_q <= READY;
            idx_q   <= LAST_RND;
            valid_q <= 1'b1;
            busy_q  <= 1'b0;
          end
        end
        READY: begin
          if (key_rewind) begin
            key_q  <= k10_q;
            idx_q  <= LAST_RND;
            last_q <= 1'b0;
          end else if (key_next && idx_q != 4'd0) begin
            key_q  <= key_inv;
            idx_q  <= idx_q - 4'd1;
            last_q <= (idx_q == 4'd1);
          end
        end
        default: ;
      endcase
    end
  end

  assign round_key_out = key_q;
  assign round_idx     = idx_q;
  assign key_valid     = valid_q;
  assign busy          = busy_q;
  assign last_key      = last_q;

endmodule

// File: tb/tb_aes_decrypt_key_expand.sv
// Bench for aes_decrypt_key_expand: table of keys with known K10/K9, an independent
// forward key-schedule model feeding a scoreboard of expected reverse-order round keys.
module tb_aes_decrypt_key_expand;

  logic         clk = 1'b0;
  logic         reset_n;
  logic [127:0] cipher_key;
  logic         key_load, key_next, key_rewind;
  logic [127:0] round_key_out;
  logic [3:0]   round_idx;
  logic         key_valid, busy, last_key;

  aes_decrypt_key_expand #(.NR(10)) dut (
    .clk(clk), .reset_n(reset_n), .cipher_key(cipher_key),
    .key_load(key_load), .key_next(key_next), .key_rewind(key_rewind),
    .round_key_out(round_key_out), .round_idx(round_idx),
    .key_valid(key_valid), .busy(busy), .last_key(last_key)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [127:0] key;
    logic [127:0] k10;
    logic [127:0] k9;
  } vec_t;

  typedef struct {
    logic [3:0]   idx;
    logic [127:0] key;
    logic         last;
  } exp_t;

  int           checks = 0;
  int           failures = 0;
  logic [7:0]   sb [256];
  logic [127:0] rk [11];
  exp_t         sb_q[$];
  vec_t         tbl [4];

  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] aa = a;
    logic [7:0] bb = b;
    for (int k = 0; k < 8; k++) begin
      if (bb[0]) p = p ^ aa;
      aa = aa[7] ? ({aa[6:0], 1'b0} ^ 8'h1b) : {aa[6:0], 1'b0};
      bb = bb >> 1;
    end
    return p;
  endfunction

  // S-box built from the GF(2^8) inverse and the affine transform.
  task automatic build_sbox();
    for (int x = 0; x < 256; x++) begin
      logic [7:0] inv = 8'h00;
      logic [7:0] s;
      for (int y = 1; y < 256; y++)
        if (x != 0 && gmul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
      s = inv ^ {inv[6:0], inv[7]} ^ {inv[5:0], inv[7:6]} ^ {inv[4:0], inv[7:5]}
          ^ {inv[3:0], inv[7:4]} ^ 8'h63;
      sb[x] = s;
    end
  endtask

  task automatic build_rk(input logic [127:0] key);
    logic [7:0]  rc = 8'h01;
    logic [31:0] w0, w1, w2, w3, t;
    rk[0] = key;
    for (int r = 1; r <= 10; r++) begin
      {w0, w1, w2, w3} = rk[r-1];
      t = {sb[w3[23:16]], sb[w3[15:8]], sb[w3[7:0]], sb[w3[31:24]]} ^ {rc, 24'h0};
      w0 = w0 ^ t; w1 = w1 ^ w0; w2 = w2 ^ w1; w3 = w3 ^ w2;
      rk[r] = {w0, w1, w2, w3};
      rc = rc[7] ? ({rc[6:0], 1'b0} ^ 8'h1b) : {rc[6:0], 1'b0};
    end
  endtask

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load a key with key_next/key_rewind held high during expansion; returns edges to key_valid.
  task automatic load_key(input logic [127:0] key, output int lat);
    cipher_key = key; key_load = 1'b1; key_next = 1'b1; key_rewind = 1'b1;
    tick();
    key_load = 1'b0;
    chk("busy_after_load", 128'(busy), 128'(1));
    chk("valid_after_load", 128'(key_valid), 128'(0));
    lat = 0;
    while (!key_valid && lat < 30) begin
      tick();
      lat++;
    end
    key_next = 1'b0; key_rewind = 1'b0;
  endtask

  task automatic step_next();
    exp_t e;
    if (round_idx != 4'd0) build_exp(round_idx - 4'd1);
    else build_exp(4'd0);
    key_next = 1'b1;
    tick();
    key_next = 1'b0;
    e = sb_q.pop_front();
    chk("next_idx", 128'(round_idx), 128'(e.idx));
    chk("next_key", round_key_out, e.key);
    chk("next_last", 128'(last_key), 128'(e.last));
    chk("next_valid", 128'(key_valid), 128'(1));
  endtask

  task automatic build_exp(input logic [3:0] i);
    exp_t e;
    e.idx = i; e.key = rk[i]; e.last = (i == 4'd0);
    sb_q.push_back(e);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_key"}, round_key_out, 128'h0);
    chk({nm, "_idx"}, 128'(round_idx), 128'h0);
    chk({nm, "_valid"}, 128'(key_valid), 128'h0);
    chk({nm, "_busy"}, 128'(busy), 128'h0);
    chk({nm, "_last"}, 128'(last_key), 128'h0);
  endtask

  initial begin
    int lat;
    reset_n = 1'b0; cipher_key = '0; key_load = 1'b0; key_next = 1'b0; key_rewind = 1'b0;
    build_sbox();

    tbl[0] = '{128'h2b7e151628aed2a6abf7158809cf4f3c,
               128'hd014f9a8c9ee2589e13f0cc8b6630ca6,
               128'hac7766f319fadc2128d12941575c006e};
    tbl[1] = '{128'h0, 128'hb4ef5bcb3e92e21123e951cf6f8f188e, 128'h0};
    tbl[2] = '{128'h000102030405060708090a0b0c0d0e0f, 128'h0, 128'h0};
    tbl[3] = '{128'hffffffffffffffffffffffffffffffff, 128'h0, 128'h0};
    build_rk(tbl[1].key); tbl[1].k9 = rk[9];
    for (int v = 2; v < 4; v++) begin
      build_rk(tbl[v].key); tbl[v].k10 = rk[10]; tbl[v].k9 = rk[9];
    end

    #12;
    chk_zero("reset");
    reset_n = 1'b1;
    tick();
    key_next = 1'b1; key_rewind = 1'b1;
    tick();
    key_next = 1'b0; key_rewind = 1'b0;
    chk_zero("idle_ignore");

    for (int v = 0; v < 4; v++) begin
      build_rk(tbl[v].key);
      load_key(tbl[v].key, lat);
      chk("latency", 128'(lat), 128'(10));
      chk("k10_idx", 128'(round_idx), 128'(10));
      chk("k10_model", round_key_out, rk[10]);
      chk("k10_table", round_key_out, tbl[v].k10);
      chk("k10_busy", 128'(busy), 128'(0));
      chk("k10_last", 128'(last_key), 128'(0));
      for (int i = 9; i >= 0; i--) begin
        step_next();
        if (i == 9) chk("k9_table", round_key_out, tbl[v].k9);
      end
      chk("k0_is_cipher_key", round_key_out, tbl[v].key);
      step_next();
    end

    // Rewind from idx 3, then rewind and key_next together from idx 7.
    build_rk(tbl[0].key);
    load_key(tbl[0].key, lat);
    for (int i = 0; i < 7; i++) step_next();
    chk("pre_rewind_idx", 128'(round_idx), 128'(3));
    key_rewind = 1'b1;
    tick();
    key_rewind = 1'b0;
    chk("rewind_idx", 128'(round_idx), 128'(10));
    chk("rewind_key", round_key_out, tbl[0].k10);
    chk("rewind_valid", 128'(key_valid), 128'(1));
    for (int i = 0; i < 3; i++) step_next();
    key_rewind = 1'b1; key_next = 1'b1;
    tick();
    key_rewind = 1'b0; key_next = 1'b0;
    chk("rewind_prio_idx", 128'(round_idx), 128'(10));
    chk("rewind_prio_key", round_key_out, tbl[0].k10);
    step_next();

    // Reload at cnt=5 restarts the expansion for the new key.
    cipher_key = tbl[2].key; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    chk("midexp_valid", 128'(key_valid), 128'(0));
    build_rk(tbl[3].key);
    load_key(tbl[3].key, lat);
    chk("reload_latency", 128'(lat), 128'(10));
    chk("reload_k10", round_key_out, tbl[3].k10);
    step_next();

    // Asynchronous reset mid-EXPAND.
    cipher_key = tbl[0].key; key_load = 1'b1;
    tick();
    key_load = 1'b0;
    tick(); tick();
    #2 reset_n = 1'b0;
    #1 chk_zero("rst_expand");
    reset_n = 1'b1;
    key_next = 1'b1;
    tick();
    key_next = 1'b0;
    chk_zero("rst_expand_after");

    // Asynchronous reset mid-READY.
    build_rk(tbl[0].key);
    load_key(tbl[0].key, lat);
    step_next();
    #2 reset_n = 1'b0;
    #1 chk_zero("rst_ready");
    reset_n = 1'b1;
    key_next = 1'b1; key_rewind = 1'b1;
    tick();
    key_next = 1'b0; key_rewind = 1'b0;
    chk_zero("rst_ready_after");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
